store_buffer: RTL



---
 rtl/store_buffer_pkg.sv | 22 ++
 rtl/sb_fifo.sv | 84 ++++++++
 rtl/store_buffer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared entry type, page-offset width and byte-offset helper
// for the two-level store buffer (store_buffer / sb_fifo).
package store_buffer_pkg;

  localparam int unsigned PAGE_OFFSET_W     = 12;
  localparam int unsigned SB_DEFAULT_ADDR_W = 64;
  localparam int unsigned SB_DEFAULT_DATA_W = 64;

  // Default-width store entry; the top level re-declares the same layout
  // sized by its own parameters and passes it to sb_fifo as a type parameter.
  typedef struct packed {
    logic [SB_DEFAULT_ADDR_W-1:0]   paddr;
    logic [SB_DEFAULT_DATA_W-1:0]   data;
    logic [SB_DEFAULT_DATA_W/8-1:0] be;
  } sb_entry_t;

  // Number of address bits that select a byte within one data word.
  function automatic int unsigned byte_ofs_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: circular queue with push/pop/flush, occupancy counter and an
// age-ordered entry/valid export (index 0 = oldest) for matching logic.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = sb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output entry_t [DEPTH-1:0]         entries_o,
  output logic   [DEPTH-1:0]         valid_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A flush drops a same-cycle push; a same-cycle pop is still honoured by
  // the reader because it consumes the head combinationally this cycle.
  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state pointers and occupancy by net delta of push and pop.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since validity comes from count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  // Export entries rotated so that index 0 is the head and validity is a
  // simple "index below occupancy" test.
  always_comb begin
    entries_o = '0;
    valid_o   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[rptr_q + PW'(i)];
      valid_o[i]   = (CW'(i) < count_q);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: two-level blocking store stage (speculative queue feeding a
// commit queue feeding the data cache port), with page-offset alias check.
// Optional store-to-load forwarding is built when STORE_BUFFER_FWD_EN is defined.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SPEC_DEPTH   = 4,
  parameter int unsigned COMMIT_DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      store_valid_i,
  output logic                      ready_o,
  input  logic [ADDRESS_SIZE-1:0]   store_paddr_i,
  input  logic [DATA_WIDTH-1:0]     store_data_i,
  input  logic [DATA_WIDTH/8-1:0]   store_be_i,
  input  logic                      commit_i,
  output logic                      commit_ready_o,
  input  logic [PAGE_OFFSET_W-1:0]  page_offset_i,
  output logic                      page_offset_matches_o,
  output logic                      no_st_pending_o,
`ifdef STORE_BUFFER_FWD_EN
  input  logic [ADDRESS_SIZE-1:0]   load_paddr_i,
  input  logic [DATA_WIDTH/8-1:0]   load_be_i,
  output logic                      fwd_valid_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
`endif
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [ADDRESS_SIZE-1:0]   mem_paddr_o,
  output logic [DATA_WIDTH-1:0]     mem_data_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o
);

  localparam int unsigned OFS = byte_ofs_bits(DATA_WIDTH);
  localparam int unsigned SCW = $clog2(SPEC_DEPTH) + 1;
  localparam int unsigned CCW = $clog2(COMMIT_DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0] paddr;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] be;
  } entry_t;

  entry_t                         store_entry;
  entry_t [SPEC_DEPTH-1:0]        spec_entries;
  logic   [SPEC_DEPTH-1:0]        spec_valid;
  entry_t [COMMIT_DEPTH-1:0]      cmt_entries;
  logic   [COMMIT_DEPTH-1:0]      cmt_valid;
  logic                           spec_full, spec_empty;
  logic                           cmt_full, cmt_empty;
  logic   [SCW-1:0]               spec_count;
  logic   [CCW-1:0]               cmt_count;
  logic                           spec_push, do_commit, mem_pop;
  entry_t                         mem_head;
  logic                           unused_ofs_lsbs;

  assign store_entry = '{paddr: store_paddr_i, data: store_data_i, be: store_be_i};

  // Readiness comes from registered occupancy only; a same-cycle pop does not
  // free a slot early.
  assign ready_o         = !spec_full;
  assign commit_ready_o  = !cmt_full;
  assign spec_push       = store_valid_i && ready_o;
  assign do_commit       = commit_i && commit_ready_o && !spec_empty;
  assign mem_req_o       = (cmt_count != '0);
  assign mem_pop         = mem_req_o && mem_gnt_i;
  assign no_st_pending_o = spec_empty && cmt_empty;

  sb_fifo #(
    .DEPTH   (SPEC_DEPTH),
    .entry_t (entry_t)
  ) u_spec_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (spec_push),
    .push_data_i (store_entry),
    .pop_i       (do_commit),
    .flush_i     (flush_i),
    .full_o      (spec_full),
    .empty_o     (spec_empty),
    .count_o     (spec_count),
    .entries_o   (spec_entries),
    .valid_o     (spec_valid)
  );

  sb_fifo #(
    .DEPTH   (COMMIT_DEPTH),
    .entry_t (entry_t)
  ) u_commit_q (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (do_commit),
    .push_data_i (spec_entries[0]),
    .pop_i       (mem_pop),
    .flush_i     (1'b0),
    .full_o      (cmt_full),
    .empty_o     (cmt_empty),
    .count_o     (cmt_count),
    .entries_o   (cmt_entries),
    .valid_o     (cmt_valid)
  );

  // Head fields are forced to zero while no request is outstanding.
  assign mem_head    = cmt_entries[0];
  assign mem_paddr_o = mem_req_o ? mem_head.paddr : '0;
  assign mem_data_o  = mem_req_o ? mem_head.data  : '0;
  assign mem_be_o    = mem_req_o ? mem_head.be    : '0;

  // Alias check: any buffered or incoming store on the same word within the page.
  always_comb begin
    page_offset_matches_o = 1'b0;
    if (store_valid_i &&
        store_paddr_i[PAGE_OFFSET_W-1:OFS] == page_offset_i[PAGE_OFFSET_W-1:OFS])
      page_offset_matches_o = 1'b1;
    for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
      if (spec_valid[i] &&
          spec_entries[i].paddr[PAGE_OFFSET_W-1:OFS] == page_offset_i[PAGE_OFFSET_W-1:OFS])
        page_offset_matches_o = 1'b1;
    end
    for (int unsigned i = 0; i < COMMIT_DEPTH; i++) begin
      if (cmt_valid[i] &&
          cmt_entries[i].paddr[PAGE_OFFSET_W-1:OFS] == page_offset_i[PAGE_OFFSET_W-1:OFS])
        page_offset_matches_o = 1'b1;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  entry_t fwd_entry;
  logic   fwd_hit;

  // Youngest matching entry wins: scan oldest to youngest (commit queue, then
  // speculative queue) and keep the last hit.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_entry = '0;
    for (int unsigned i = 0; i < COMMIT_DEPTH; i++) begin
      if (cmt_valid[i] &&
          cmt_entries[i].paddr[ADDRESS_SIZE-1:OFS] == load_paddr_i[ADDRESS_SIZE-1:OFS]) begin
        fwd_hit   = 1'b1;
        fwd_entry = cmt_entries[i];
      end
    end
    for (int unsigned i = 0; i < SPEC_DEPTH; i++) begin
      if (spec_valid[i] &&
          spec_entries[i].paddr[ADDRESS_SIZE-1:OFS] == load_paddr_i[ADDRESS_SIZE-1:OFS]) begin
        fwd_hit   = 1'b1;
        fwd_entry = spec_entries[i];
      end
    end
  end

  assign fwd_valid_o = fwd_hit && ((fwd_entry.be & load_be_i) == load_be_i);
  assign fwd_data_o  = fwd_valid_o ? fwd_entry.data : '0;

  assign unused_ofs_lsbs = ^{page_offset_i[OFS-1:0], load_paddr_i[OFS-1:0]};
`else
  assign unused_ofs_lsbs = ^page_offset_i[OFS-1:0];
`endif

`ifndef SYNTHESIS
  // Upstream must not commit when there is nothing speculative to commit.
  a_commit_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    commit_i |-> (spec_count != '0));

  // An outstanding memory request and its head fields hold until granted.
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_paddr_o) &&
                                   $stable(mem_data_o) && $stable(mem_be_o)));
`endif

endmodule
